trap_controller: RTL and testbench



---
 rtl/trap_controller.sv | 210 +++++++++++++++++++++
 tb/tb_trap_controller.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/trap_controller.sv
// -----------------------------------------------------------------------------
// trap_controller
//
// Machine-mode trap sequencer. It arbitrates between synchronous exceptions,
// pending interrupts and MRET. For a trap it waits for any outstanding
// data-bus transaction to drain, commits mepc/mcause/mstatus and issues a
// one-cycle PC redirect with a full pipeline flush. It also owns the trap
// CSRs and serves the CSR instruction path.
//
// Ports:
//   clk, nrst        clock, asynchronous active-low reset
//   exc_req/cause/pc synchronous exception request, cause code and faulting PC
//   irq[2:0]         level interrupts {external, software, timer}
//   irq_pc(_valid)   PC of the oldest uncommitted instruction, and its valid
//   mret_req         MRET has reached the memory stage
//   mem_busy         a data-bus transaction is outstanding
//   csr_we/addr/wdata  CSR write port
//   csr_rdata        combinational CSR read of csr_addr
//   flush_all        flush every pipeline register
//   redirect(_pc)    one-cycle PC redirect and its target
//   busy             controller is not idle; stalls fetch
// -----------------------------------------------------------------------------
module trap_controller #(
  parameter logic [31:0] RESET_MTVEC = 32'h0000_8000,
  parameter int unsigned NUM_IRQ     = 3
) (
  input  logic               clk,
  input  logic               nrst,
  input  logic               exc_req,
  input  logic [31:0]        exc_cause,
  input  logic [31:0]        exc_pc,
  input  logic [NUM_IRQ-1:0] irq,
  input  logic [31:0]        irq_pc,
  input  logic               irq_pc_valid,
  input  logic               mret_req,
  input  logic               mem_busy,
  input  logic               csr_we,
  input  logic [11:0]        csr_addr,
  input  logic [31:0]        csr_wdata,
  output logic [31:0]        csr_rdata,
  output logic               flush_all,
  output logic               redirect,
  output logic [31:0]        redirect_pc,
  output logic               busy
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_DRAIN  = 2'd1;
  localparam logic [1:0] S_COMMIT = 2'd2;
  localparam logic [1:0] S_RETURN = 2'd3;

  localparam logic [11:0] A_MSTATUS = 12'h300;
  localparam logic [11:0] A_MIE     = 12'h304;
  localparam logic [11:0] A_MTVEC   = 12'h305;
  localparam logic [11:0] A_MEPC    = 12'h341;
  localparam logic [11:0] A_MCAUSE  = 12'h342;
  localparam logic [11:0] A_MIP     = 12'h344;

  logic [1:0]  state_q, state_d;
  logic [31:0] trap_pc_q, trap_pc_d;       // PC latched at trap detection
  logic [31:0] trap_cause_q, trap_cause_d; // cause latched at trap detection
  logic [31:0] mtvec_q, mtvec_d;
  logic [31:0] mepc_q, mepc_d;
  logic [31:0] mcause_q, mcause_d;
  logic        st_mie_q, st_mie_d;
  logic        st_mpie_q, st_mpie_d;
  // Interrupt bits stored compactly as {bit 11, bit 7, bit 3}.
  logic [2:0]  mie_q, mie_d;

  logic [2:0]  mip_bits;
  logic [2:0]  irq_pend;
  logic        irq_take;
  logic [3:0]  irq_code;
  logic        csr_wr_ok;
  logic [31:0] mtvec_base;

  // mip layout: bit 11 = external, bit 7 = timer, bit 3 = software.
  assign mip_bits = {irq[2], irq[0], irq[1]};
  assign irq_pend = mip_bits & mie_q;
  assign irq_take = st_mie_q & irq_pc_valid & (|irq_pend);

  // Fixed priority: external (11) > software (3) > timer (7).
  always_comb begin
    if (irq_pend[2])      irq_code = 4'd11;
    else if (irq_pend[0]) irq_code = 4'd3;
    else                  irq_code = 4'd7;
  end

  assign busy       = (state_q != S_IDLE);
  assign mtvec_base = {mtvec_q[31:2], 2'b00};
  // Software writes are dropped while the bus drains.
  assign csr_wr_ok  = csr_we && (state_q != S_DRAIN);

  always_comb begin
    case (csr_addr)
      A_MSTATUS: csr_rdata = {24'b0, st_mpie_q, 3'b0, st_mie_q, 3'b0};
      A_MIE:     csr_rdata = {20'b0, mie_q[2], 3'b0, mie_q[1], 3'b0, mie_q[0], 3'b0};
      A_MTVEC:   csr_rdata = mtvec_q;
      A_MEPC:    csr_rdata = mepc_q;
      A_MCAUSE:  csr_rdata = mcause_q;
      A_MIP:     csr_rdata = {20'b0, mip_bits[2], 3'b0, mip_bits[1], 3'b0, mip_bits[0], 3'b0};
      default:   csr_rdata = 32'b0;
    endcase
  end

  always_comb begin
    // NOTE: every signal driven here gets a default first so no path leaves
    // it unassigned; without that, synthesis would infer latches.
    state_d      = state_q;
    trap_pc_d    = trap_pc_q;
    trap_cause_d = trap_cause_q;
    mtvec_d      = mtvec_q;
    mepc_d       = mepc_q;
    mcause_d     = mcause_q;
    st_mie_d     = st_mie_q;
    st_mpie_d    = st_mpie_q;
    mie_d        = mie_q;
    flush_all    = 1'b0;
    redirect     = 1'b0;
    redirect_pc  = 32'b0;

    // CSR writes apply first, so any trap update below overrides them when
    // both target the same register in the same cycle.
    if (csr_wr_ok) begin
      case (csr_addr)
        A_MSTATUS: begin
          st_mie_d  = csr_wdata[3];
          st_mpie_d = csr_wdata[7];
        end
        A_MIE:    mie_d    = {csr_wdata[11], csr_wdata[7], csr_wdata[3]};
        A_MTVEC:  mtvec_d  = csr_wdata;
        A_MEPC:   mepc_d   = {csr_wdata[31:2], 2'b00};
        A_MCAUSE: mcause_d = csr_wdata;
        default:  ;
      endcase
    end

    case (state_q)
      S_IDLE: begin
        if (exc_req) begin
          trap_pc_d    = exc_pc;
          trap_cause_d = exc_cause;
        end else if (irq_take) begin
          trap_pc_d    = irq_pc;
          trap_cause_d = {1'b1, 27'b0, irq_code};
        end else if (mret_req) begin
          state_d = S_RETURN;
        end
        if (exc_req || irq_take) begin
          flush_all = 1'b1;
          state_d   = mem_busy ? S_DRAIN : S_COMMIT;
        end
      end
      S_DRAIN: begin
        flush_all = 1'b1;
        if (!mem_busy) state_d = S_COMMIT;
      end
      S_COMMIT: begin
        flush_all = 1'b1;
        redirect  = 1'b1;
        mepc_d    = trap_pc_q;
        mcause_d  = trap_cause_q;
        st_mpie_d = st_mie_q;
        st_mie_d  = 1'b0;
        // Vectored mode only applies to interrupts; exceptions use the base.
        if (mtvec_q[1:0] == 2'b01 && trap_cause_q[31])
          redirect_pc = mtvec_base + {26'b0, trap_cause_q[3:0], 2'b00};
        else
          redirect_pc = mtvec_base;
        state_d = S_IDLE;
      end
      S_RETURN: begin
        flush_all   = 1'b1;
        redirect    = 1'b1;
        redirect_pc = mepc_q;
        st_mie_d    = st_mpie_q;
        st_mpie_d   = 1'b1;
        state_d     = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the values from before the edge, independent of statement order.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q      <= S_IDLE;
      trap_pc_q    <= 32'b0;
      trap_cause_q <= 32'b0;
      mtvec_q      <= RESET_MTVEC;
      mepc_q       <= 32'b0;
      mcause_q     <= 32'b0;
      st_mie_q     <= 1'b0;
      st_mpie_q    <= 1'b0;
      mie_q        <= 3'b0;
    end else begin
      state_q      <= state_d;
      trap_pc_q    <= trap_pc_d;
      trap_cause_q <= trap_cause_d;
      mtvec_q      <= mtvec_d;
      mepc_q       <= mepc_d;
      mcause_q     <= mcause_d;
      st_mie_q     <= st_mie_d;
      st_mpie_q    <= st_mpie_d;
      mie_q        <= mie_d;
    end
  end

endmodule

// File: tb/tb_trap_controller.sv
// -----------------------------------------------------------------------------
// tb_trap_controller
//
// Directed self-checking bench for trap_controller. Inputs change 1 ns after
// the rising edge; combinational outputs are sampled later in the same cycle.
// -----------------------------------------------------------------------------
module tb_trap_controller;

  logic        clk;
  logic        nrst;
  logic        exc_req;
  logic [31:0] exc_cause;
  logic [31:0] exc_pc;
  logic [2:0]  irq;
  logic [31:0] irq_pc;
  logic        irq_pc_valid;
  logic        mret_req;
  logic        mem_busy;
  logic        csr_we;
  logic [11:0] csr_addr;
  logic [31:0] csr_wdata;
  logic [31:0] csr_rdata;
  logic        flush_all;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        busy;

  int n_checks = 0;
  int n_pass   = 0;

  trap_controller #(
    .RESET_MTVEC(32'h0000_8000),
    .NUM_IRQ    (3)
  ) dut (
    .clk         (clk),
    .nrst        (nrst),
    .exc_req     (exc_req),
    .exc_cause   (exc_cause),
    .exc_pc      (exc_pc),
    .irq         (irq),
    .irq_pc      (irq_pc),
    .irq_pc_valid(irq_pc_valid),
    .mret_req    (mret_req),
    .mem_busy    (mem_busy),
    .csr_we      (csr_we),
    .csr_addr    (csr_addr),
    .csr_wdata   (csr_wdata),
    .csr_rdata   (csr_rdata),
    .flush_all   (flush_all),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic csr_write(input logic [11:0] a, input logic [31:0] d);
    csr_we    = 1'b1;
    csr_addr  = a;
    csr_wdata = d;
    step();
    csr_we    = 1'b0;
  endtask

  task automatic check_csr(input string tag, input logic [11:0] a, input logic [31:0] exp);
    csr_addr = a;
    #1;
    check(tag, csr_rdata, exp);
  endtask

  int flush_cnt;
  int redir_cyc;
  int redir_seen;

  initial begin
    nrst = 1'b0; exc_req = 1'b0; exc_cause = '0; exc_pc = '0; irq = '0;
    irq_pc = '0; irq_pc_valid = 1'b0; mret_req = 1'b0; mem_busy = 1'b0;
    csr_we = 1'b0; csr_addr = '0; csr_wdata = '0;
    repeat (2) @(posedge clk);
    #1 nrst = 1'b1;
    #1;

    // Reset state
    check("rst_busy", busy, 0);
    check("rst_redirect", redirect, 0);
    check("rst_flush", flush_all, 0);
    check("rst_redirect_pc", redirect_pc, 0);
    check_csr("rst_mtvec", 12'h305, 32'h8000);
    check_csr("rst_mstatus", 12'h300, 0);
    check_csr("rst_mie", 12'h304, 0);
    check_csr("rst_mepc", 12'h341, 0);
    check_csr("rst_mcause", 12'h342, 0);
    check_csr("unmapped", 12'h7C0, 0);
    step();

    // Exception, no bus activity: redirect on the next cycle
    csr_write(12'h300, 32'h8);
    exc_cause = 32'd2; exc_pc = 32'h104; exc_req = 1'b1;
    #1;
    check("exc_detect_flush", flush_all, 1);
    check("exc_detect_busy", busy, 0);
    check("exc_detect_redirect", redirect, 0);
    step();
    exc_req = 1'b0;
    #1;
    check("exc_commit_redirect", redirect, 1);
    check("exc_commit_pc", redirect_pc, 32'h8000);
    check("exc_commit_busy", busy, 1);
    check("exc_commit_flush", flush_all, 1);
    step();
    check("exc_after_redirect", redirect, 0);
    check("exc_after_busy", busy, 0);
    check_csr("exc_mepc", 12'h341, 32'h104);
    check_csr("exc_mcause", 12'h342, 32'd2);
    check_csr("exc_mstatus", 12'h300, 32'h80);
    step();

    // Exception with mem_busy high for 3 cycles; CSR write in DRAIN dropped
    exc_cause = 32'd5; exc_pc = 32'h108; exc_req = 1'b1;
    csr_addr = 12'h305; csr_wdata = 32'h9000;
    flush_cnt = 0; redir_cyc = -1;
    for (int c = 0; c < 12; c++) begin
      mem_busy = (c < 3);
      csr_we   = (c == 2);
      #1;
      if (redirect) begin
        redir_cyc = c;
        check("drain_redirect_pc", redirect_pc, 32'h8000);
        break;
      end
      if (flush_all) flush_cnt++;
      @(posedge clk);
      #1;
      exc_req = 1'b0;
    end
    csr_we = 1'b0; mem_busy = 1'b0;
    check("drain_redirect_cycle", redir_cyc, 4);
    check("drain_flush_cycles", flush_cnt, 4);
    step();
    check_csr("drain_mcause", 12'h342, 32'd5);
    check_csr("drain_mepc", 12'h341, 32'h108);
    check_csr("drain_mtvec_kept", 12'h305, 32'h8000);
    check_csr("drain_mstatus", 12'h300, 32'h0);
    step();

    // Vectored timer interrupt
    csr_write(12'h305, 32'h8001);
    csr_write(12'h304, 32'h80);
    csr_write(12'h300, 32'h8);
    check_csr("vec_mie", 12'h304, 32'h80);
    irq = 3'b001; irq_pc = 32'h200; irq_pc_valid = 1'b0;
    #1;
    check("vec_pc_invalid_noflush", flush_all, 0);
    check_csr("vec_mip", 12'h344, 32'h80);
    irq_pc_valid = 1'b1;
    #1;
    check("vec_detect_flush", flush_all, 1);
    step();
    check("vec_commit_redirect", redirect, 1);
    check("vec_commit_pc", redirect_pc, 32'h801C);
    irq = 3'b000;
    step();
    check_csr("vec_mcause", 12'h342, 32'h8000_0007);
    check_csr("vec_mepc", 12'h341, 32'h200);
    step();

    // Exception beats simultaneous interrupts; MRET then lets external in
    csr_write(12'h304, 32'h888);
    csr_write(12'h300, 32'h8);
    check_csr("prio_mie", 12'h304, 32'h888);
    irq = 3'b111; irq_pc = 32'h300;
    exc_cause = 32'hD; exc_pc = 32'h400; exc_req = 1'b1;
    check_csr("prio_mip", 12'h344, 32'h888);
    check("prio_detect_flush", flush_all, 1);
    step();
    exc_req = 1'b0;
    #1;
    check("prio_exc_vec_base", redirect_pc, 32'h8000);
    step();
    check_csr("prio_mcause", 12'h342, 32'hD);
    check_csr("prio_mepc", 12'h341, 32'h400);
    check_csr("prio_mstatus", 12'h300, 32'h80);
    check("prio_masked_noflush", flush_all, 0);
    mret_req = 1'b1;
    step();
    mret_req = 1'b0;
    #1;
    check("mret_redirect", redirect, 1);
    check("mret_pc", redirect_pc, 32'h400);
    step();
    check_csr("mret_mstatus", 12'h300, 32'h88);
    check("ext_detect_flush", flush_all, 1);
    step();
    check("ext_commit_pc", redirect_pc, 32'h802C);
    irq = 3'b000;
    step();
    check_csr("ext_mcause", 12'h342, 32'h8000_000B);
    check_csr("ext_mepc", 12'h341, 32'h300);
    step();

    // mepc alignment and MRET; a same-cycle mstatus write loses to RETURN
    csr_write(12'h341, 32'h303);
    check_csr("mepc_aligned", 12'h341, 32'h300);
    csr_write(12'h300, 32'h0);
    mret_req = 1'b1;
    step();
    mret_req = 1'b0;
    csr_we = 1'b1; csr_addr = 12'h300; csr_wdata = 32'h8;
    #1;
    check("ret_redirect", redirect, 1);
    check("ret_pc", redirect_pc, 32'h300);
    step();
    csr_we = 1'b0;
    check_csr("ret_mstatus", 12'h300, 32'h80);
    step();

    // Reset in the middle of DRAIN
    exc_cause = 32'd7; exc_pc = 32'h500; exc_req = 1'b1; mem_busy = 1'b1;
    step();
    exc_req = 1'b0;
    #1;
    check("rstd_drain_busy", busy, 1);
    check("rstd_drain_flush", flush_all, 1);
    nrst = 1'b0;
    #1;
    check("rstd_busy", busy, 0);
    check("rstd_flush", flush_all, 0);
    check("rstd_redirect", redirect, 0);
    #2 nrst = 1'b1;
    mem_busy = 1'b0;
    redir_seen = 0;
    for (int c = 0; c < 5; c++) begin
      step();
      if (redirect) redir_seen++;
    end
    check("rstd_no_redirect", redir_seen, 0);
    check("rstd_idle", busy, 0);
    check_csr("rstd_mtvec", 12'h305, 32'h8000);
    check_csr("rstd_mstatus", 12'h300, 0);
    check_csr("rstd_mie", 12'h304, 0);
    check_csr("rstd_mepc", 12'h341, 0);
    check_csr("rstd_mcause", 12'h342, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
